// File: rtl/matvec_pkg.sv
`default_nettype none
// ============================================================================
// Module   : matvec_pkg
// Purpose  : Shared sizes, coefficient matrix and FSM state types for the
//            matrix-vector stream port.
// Revision : 1.0
// ============================================================================
package matvec_pkg;

    localparam int ROWS  = 3;
    localparam int COLS  = 3;
    localparam int IN_W  = 4;
    localparam int OUT_W = 23;
    localparam int CNT_W = 2;

    // Matrix the constant-coefficient core is generated from.
    localparam logic signed [15:0] COEF [ROWS][COLS] = '{
        '{ 16'sd3,     -16'sd5,   16'sd7    },
        '{ -16'sd1200,  16'sd250, 16'sh8000 },
        '{ 16'sd0,      16'sd100, -16'sd2   }
    };

    typedef logic [COLS-1:0][IN_W-1:0]  xvec_t;
    typedef logic [ROWS-1:0][OUT_W-1:0] yvec_t;

    typedef enum logic [0:0] {FILL = 1'b0, FULL = 1'b1} in_state_e;
    typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} out_state_e;

endpackage
`default_nettype wire

// File: rtl/matvec_stream_port_if.sv
`default_nettype none
// ============================================================================
// Module   : matvec_stream_port_if
// Purpose  : Input element stream and output result stream of the
//            matrix-vector port, plus its frame-error pulse.
// Revision : 1.0
// ============================================================================
interface matvec_stream_port_if;
    import matvec_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [CNT_W-1:0] out_idx;
    logic             out_last;
    logic             frame_err;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last, frame_err
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last, frame_err
    );

endinterface
`default_nettype wire

// File: rtl/matvec_stream_port_matrix_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : matrix_multiplier
// Purpose  : Combinational constant-coefficient core, y = COEF * x with
//            unsigned x and two's-complement y.
// Revision : 1.0
// ============================================================================
module matrix_multiplier
    import matvec_pkg::*;
(
    input  xvec_t i_x,
    output yvec_t o_y
);

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic signed [OUT_W-1:0] w_acc;

        always_comb begin
            w_acc = '0;
            for (int c = 0; c < COLS; c++) begin
                // Zero-extend the element so it stays non-negative once signed.
                w_acc = w_acc + OUT_W'($signed({1'b0, i_x[c]})) * OUT_W'(COEF[r][c]);
            end
        end

        assign o_y[r] = w_acc;
    end

endmodule
`default_nettype wire

// File: rtl/matvec_stream_port.sv
`default_nettype none
// ============================================================================
// Module   : matvec_stream_port
// Purpose  : Deserialises COLS input elements into the core, registers the
//            ROWS results and serialises them out under valid/ready.
// Revision : 1.0
// ============================================================================
module matvec_stream_port
    import matvec_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    matvec_stream_port_if.slave bus
);

    localparam logic [CNT_W-1:0] c_col_last = CNT_W'(COLS - 1);
    localparam logic [CNT_W-1:0] c_row_last = CNT_W'(ROWS - 1);

    in_state_e        r_in_state,  w_in_state_nxt;
    out_state_e       r_out_state, w_out_state_nxt;
    logic [CNT_W-1:0] r_col_cnt,   w_col_cnt_nxt;
    logic [CNT_W-1:0] r_row_cnt,   w_row_cnt_nxt;
    logic             r_frame_err, w_frame_err_nxt;
    xvec_t            r_xbuf;
    yvec_t            r_ybuf;
    yvec_t            w_ybuf_d;

    logic w_in_ready;
    logic w_in_fire;
    logic w_sending;
    logic w_last_beat;
    logic w_load;

    matrix_multiplier u_core (
        .i_x (r_xbuf),
        .o_y (w_ybuf_d)
    );

    assign w_in_ready  = (r_in_state == FILL);
    assign w_in_fire   = bus.in_valid & w_in_ready;
    assign w_sending   = (r_out_state == SEND);
    assign w_last_beat = w_sending & (r_row_cnt == c_row_last) & bus.out_ready;
    // A full vector loads as soon as the result register is free or freeing.
    assign w_load      = (r_in_state == FULL) & ((r_out_state == IDLE) | w_last_beat);

    always_comb begin
        w_in_state_nxt  = r_in_state;
        w_col_cnt_nxt   = r_col_cnt;
        w_frame_err_nxt = 1'b0;
        case (r_in_state)
            FILL: begin
                if (w_in_fire) begin
                    if (r_col_cnt == c_col_last) begin
                        w_col_cnt_nxt = '0;
                        if (bus.in_last) begin
                            w_in_state_nxt = FULL;
                        end else begin
                            w_frame_err_nxt = 1'b1;
                        end
                    end else if (bus.in_last) begin
                        w_col_cnt_nxt   = '0;
                        w_frame_err_nxt = 1'b1;
                    end else begin
                        w_col_cnt_nxt = r_col_cnt + 1'b1;
                    end
                end
            end
            FULL: begin
                if (w_load) begin
                    w_in_state_nxt = FILL;
                end
            end
            default: w_in_state_nxt = FILL;
        endcase
    end

    always_comb begin
        w_out_state_nxt = r_out_state;
        w_row_cnt_nxt   = r_row_cnt;
        case (r_out_state)
            IDLE: begin
                if (w_load) begin
                    w_out_state_nxt = SEND;
                    w_row_cnt_nxt   = '0;
                end
            end
            SEND: begin
                if (bus.out_ready) begin
                    if (r_row_cnt == c_row_last) begin
                        w_row_cnt_nxt   = '0;
                        w_out_state_nxt = w_load ? SEND : IDLE;
                    end else begin
                        w_row_cnt_nxt = r_row_cnt + 1'b1;
                    end
                end
            end
            default: w_out_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_state  <= FILL;
            r_out_state <= IDLE;
            r_col_cnt   <= '0;
            r_row_cnt   <= '0;
            r_frame_err <= 1'b0;
            r_xbuf      <= '0;
            r_ybuf      <= '0;
        end else begin
            r_in_state  <= w_in_state_nxt;
            r_out_state <= w_out_state_nxt;
            r_col_cnt   <= w_col_cnt_nxt;
            r_row_cnt   <= w_row_cnt_nxt;
            r_frame_err <= w_frame_err_nxt;
            if (w_in_fire) begin
                r_xbuf[r_col_cnt] <= bus.in_data;
            end
            if (w_load) begin
                r_ybuf <= w_ybuf_d;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_sending;
    assign bus.out_data  = w_sending ? r_ybuf[r_row_cnt] : '0;
    assign bus.out_idx   = r_row_cnt;
    assign bus.out_last  = w_sending & (r_row_cnt == c_row_last);
    assign bus.frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_matvec_stream_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_matvec_stream_port
// Purpose  : Directed self-checking bench for matvec_stream_port.
// Revision : 1.0
// ============================================================================
module tb_matvec_stream_port;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    matvec_stream_port_if bus ();

    matvec_stream_port dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int q_data[$];
    int q_idx[$];
    int q_last[$];
    int exp_q[$];
    int rd       = 0;
    int ferr_cnt = 0;
    bit rnd_done = 1'b0;

    int coef_tb [3][3] = '{'{3, -5, 7}, '{-1200, 250, -32768}, '{0, 100, -2}};

    // Record every accepted output beat and every frame_err pulse.
    always @(posedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            q_data.push_back(int'($signed(bus.out_data)));
            q_idx.push_back(int'(bus.out_idx));
            q_last.push_back(int'(bus.out_last));
        end
        if (!rst && bus.frame_err) ferr_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int d, input bit last);
        int guard = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = 4'(d);
        bus.in_last  = last;
        while (!bus.in_ready && guard < 200) begin
            tick();
            guard++;
        end
        if (guard >= 200) chk("send_ready", int'(bus.in_ready), 1);
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic send_vec(input int x0, input int x1, input int x2);
        send(x0, 1'b0);
        send(x1, 1'b0);
        send(x2, 1'b1);
    endtask

    task automatic expect_beat(input string tag, input int exp_d, input int exp_i);
        int guard = 0;
        while (q_data.size() <= rd && guard < 500) begin
            tick();
            guard++;
        end
        if (q_data.size() <= rd) begin
            chk({tag, "_timeout"}, q_data.size(), rd + 1);
        end else begin
            chk({tag, "_data"}, q_data[rd], exp_d);
            chk({tag, "_idx"},  q_idx[rd],  exp_i);
            chk({tag, "_last"}, q_last[rd], int'(exp_i == 2));
            rd++;
        end
    endtask

    function automatic int model(input int r, input int x0, input int x1, input int x2);
        return coef_tb[r][0] * x0 + coef_tb[r][1] * x1 + coef_tb[r][2] * x2;
    endfunction

    initial begin
        int hd, hi, guard, qs, fbase;
        bit pat;
        bit [7:0] rdy_pat;
        rdy_pat = 8'b0110_1001;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        chk("rst_in_ready",  int'(bus.in_ready),  1);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_data",  int'(bus.out_data),  0);
        chk("rst_out_idx",   int'(bus.out_idx),   0);
        chk("rst_out_last",  int'(bus.out_last),  0);
        chk("rst_frame_err", int'(bus.frame_err), 0);
        rst = 1'b0;
        tick();

        // 1: zero vector, latency check
        bus.out_ready = 1'b1;
        send_vec(0, 0, 0);
        chk("lat_t0_valid", int'(bus.out_valid), 0);
        tick();
        chk("lat_t1_valid", int'(bus.out_valid), 1);
        chk("lat_t1_idx",   int'(bus.out_idx),   0);
        expect_beat("zero0", 0, 0);
        expect_beat("zero1", 0, 1);
        expect_beat("zero2", 0, 2);

        // 2: two vectors back to back
        send_vec(1, 0, 0);
        send_vec(0, 0, 15);
        expect_beat("b2b_a0", 3, 0);
        expect_beat("b2b_a1", -1200, 1);
        expect_beat("b2b_a2", 0, 2);
        expect_beat("b2b_b0", 105, 0);
        expect_beat("b2b_b1", -491520, 1);
        expect_beat("b2b_b2", -30, 2);

        // 3: back-pressure, outputs hold while ready is low
        bus.out_ready = 1'b0;
        send_vec(15, 15, 15);
        guard = 0;
        while (!bus.out_valid && guard < 50) begin
            tick();
            guard++;
        end
        chk("bp_valid", int'(bus.out_valid), 1);
        for (int i = 0; i < 40 && q_data.size() < rd + 3; i++) begin
            pat = rdy_pat[i % 8];
            bus.out_ready = pat;
            hd = int'($signed(bus.out_data));
            hi = int'(bus.out_idx);
            tick();
            if (!pat) begin
                chk("bp_hold_data",  int'($signed(bus.out_data)), hd);
                chk("bp_hold_idx",   int'(bus.out_idx),           hi);
                chk("bp_hold_valid", int'(bus.out_valid),         1);
            end
        end
        bus.out_ready = 1'b1;
        expect_beat("bp0", 75, 0);
        expect_beat("bp1", -505770, 1);
        expect_beat("bp2", 1470, 2);

        // 4: early in_last -> frame error, vector dropped
        fbase = ferr_cnt;
        qs    = q_data.size();
        send(5, 1'b0);
        send(6, 1'b1);
        chk("ferr_pulse", int'(bus.frame_err), 1);
        tick();
        chk("ferr_clear", int'(bus.frame_err), 0);
        repeat (5) tick();
        chk("ferr_no_out", q_data.size(), qs);
        chk("ferr_count",  ferr_cnt - fbase, 1);
        send_vec(2, 3, 4);
        expect_beat("fr0", 19, 0);
        expect_beat("fr1", -132722, 1);
        expect_beat("fr2", 292, 2);

        // 5: reset after the second beat of a vector
        send_vec(7, 7, 7);
        guard = 0;
        while (q_data.size() < rd + 2 && guard < 50) begin
            tick();
            guard++;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid",    int'(bus.out_valid), 0);
        chk("mid_rst_in_ready", int'(bus.in_ready),  1);
        expect_beat("mr0", 35, 0);
        expect_beat("mr1", -236026, 1);
        repeat (6) tick();
        chk("mid_rst_dropped", q_data.size(), rd);
        send_vec(1, 2, 3);
        expect_beat("post0", 14, 0);
        expect_beat("post1", -99004, 1);
        expect_beat("post2", 194, 2);

        // 6: random vectors with valid and ready gaps
        fork
            begin
                int x0, x1, x2;
                for (int v = 0; v < 30; v++) begin
                    x0 = int'($urandom_range(0, 15));
                    x1 = int'($urandom_range(0, 15));
                    x2 = int'($urandom_range(0, 15));
                    for (int r = 0; r < 3; r++) exp_q.push_back(model(r, x0, x1, x2));
                    repeat ($urandom_range(0, 2)) tick();
                    send(x0, 1'b0);
                    repeat ($urandom_range(0, 2)) tick();
                    send(x1, 1'b0);
                    repeat ($urandom_range(0, 2)) tick();
                    send(x2, 1'b1);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    tick();
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
                bus.out_ready = 1'b1;
            end
        join
        for (int k = 0; k < exp_q.size(); k++) begin
            expect_beat("rnd", exp_q[k], k % 3);
        end
        repeat (10) tick();
        chk("rnd_beat_count", q_data.size(), rd);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
